// File: rtl/fir_input_sequencer.sv
`timescale 1ns/1ps
// fir_input_sequencer: upstream feeder for fir_filter.
// Buffers source samples in a FIFO and sequences sample and coefficient
// handshakes toward the filter, one transfer at a time, with timeouts.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   in_data/valid    sample source; in_ready = FIFO not full (registered)
//   coeff_set        NUM_COEFF coefficients, k at [k*DATA_W +: DATA_W]
//   coeff_start      one-cycle request to load coeff_set
//   modwait          filter busy flag (rise = accepted, fall = done)
//   sample_data,
//   data_ready       sample handshake to the filter
//   fir_coefficient,
//   load_coeff       coefficient handshake to the filter
//   coeff_busy       coefficient sequence in progress
//   fifo_count       occupied FIFO entries
//   timeout_err      sticky handshake-timeout flag
module fir_input_sequencer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_COEFF  = 4,
    parameter int LC_PULSE   = 2,
    parameter int S_TIMEOUT  = 25,
    parameter int C_TIMEOUT  = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_COEFF*DATA_W-1:0] coeff_set,
    input  logic                        coeff_start,
    input  logic                        modwait,
    output logic [DATA_W-1:0]           sample_data,
    output logic                        data_ready,
    output logic [DATA_W-1:0]           fir_coefficient,
    output logic                        load_coeff,
    output logic                        coeff_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        timeout_err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int KI   = $clog2(NUM_COEFF);
    localparam int PW   = $clog2(LC_PULSE + 1);
    localparam int TMAX = (S_TIMEOUT > C_TIMEOUT) ? S_TIMEOUT : C_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        C_PULSE,
        C_WAIT,
        S_REQ,
        S_WAIT,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              in_ready_q;
    logic              push, pop;

    logic [DATA_W-1:0] coef_q [NUM_COEFF];
    logic [DATA_W-1:0] coef_d [NUM_COEFF];
    logic [KI-1:0]     k_q, k_d, k_nxt;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [TW-1:0]     tmr_q, tmr_d, tmr_inc;
    logic              seen_q, seen_d;
    logic              pend_q, pend_d;
    logic              mw_q;
    logic              rise, fall, s_tmo, c_tmo;

    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] fc_q, fc_d;
    logic              dr_q, dr_d;
    logic              lc_q, lc_d;
    logic              cb_q, cb_d;
    logic              err_q, err_d;

    assign push    = in_valid && in_ready_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign rise    = modwait && !mw_q;
    assign fall    = !modwait && mw_q;
    assign tmr_inc = tmr_q + TW'(1);
    assign s_tmo   = (tmr_inc == TW'(S_TIMEOUT));
    assign c_tmo   = (tmr_inc == TW'(C_TIMEOUT));
    assign k_nxt   = k_q + KI'(1);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        pcnt_d   = pcnt_q;
        tmr_d    = tmr_q;
        seen_d   = seen_q;
        pend_d   = pend_q;
        coef_d   = coef_q;
        sample_d = sample_q;
        fc_d     = fc_q;
        dr_d     = dr_q;
        lc_d     = lc_q;
        cb_d     = cb_q;
        err_d    = err_q;
        pop      = 1'b0;

        // One-deep memory of a start request that arrives while busy.
        if (coeff_start && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (coeff_start || pend_q) begin
                    for (int i = 0; i < NUM_COEFF; i++) begin
                        coef_d[i] = coeff_set[i*DATA_W +: DATA_W];
                    end
                    pend_d  = 1'b0;
                    k_d     = '0;
                    pcnt_d  = '0;
                    tmr_d   = '0;
                    seen_d  = 1'b0;
                    fc_d    = coeff_set[0 +: DATA_W];
                    lc_d    = 1'b1;
                    cb_d    = 1'b1;
                    state_d = C_PULSE;
                end else if (count_q != '0) begin
                    pop      = 1'b1;
                    sample_d = mem_q[rd_ptr_q];
                    dr_d     = 1'b1;
                    tmr_d    = '0;
                    state_d  = S_REQ;
                end
            end
            C_PULSE: begin
                tmr_d  = tmr_inc;
                seen_d = seen_q || rise;
                if (c_tmo) begin
                    err_d   = 1'b1;
                    lc_d    = 1'b0;
                    cb_d    = 1'b0;
                    state_d = GAP;
                end else if (pcnt_q + PW'(1) == PW'(LC_PULSE)) begin
                    lc_d    = 1'b0;
                    state_d = C_WAIT;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            C_WAIT: begin
                tmr_d  = tmr_inc;
                seen_d = seen_q || rise;
                // Only a fall that follows an observed rise ends the transfer.
                if (fall && seen_q) begin
                    if (k_q == KI'(NUM_COEFF - 1)) begin
                        cb_d    = 1'b0;
                        state_d = GAP;
                    end else begin
                        k_d     = k_nxt;
                        fc_d    = coef_q[k_nxt];
                        lc_d    = 1'b1;
                        pcnt_d  = '0;
                        tmr_d   = '0;
                        seen_d  = 1'b0;
                        state_d = C_PULSE;
                    end
                end else if (c_tmo) begin
                    err_d   = 1'b1;
                    cb_d    = 1'b0;
                    state_d = GAP;
                end
            end
            S_REQ: begin
                tmr_d = tmr_inc;
                if (s_tmo) begin
                    err_d   = 1'b1;
                    dr_d    = 1'b0;
                    state_d = GAP;
                end else if (rise) begin
                    dr_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmr_d = tmr_inc;
                if (fall) begin
                    state_d = GAP;
                end else if (s_tmo) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            coef_q     <= '{default: '0};
            k_q        <= '0;
            pcnt_q     <= '0;
            tmr_q      <= '0;
            seen_q     <= 1'b0;
            pend_q     <= 1'b0;
            mw_q       <= 1'b0;
            sample_q   <= '0;
            fc_q       <= '0;
            dr_q       <= 1'b0;
            lc_q       <= 1'b0;
            cb_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_d;
            in_ready_q <= (count_d != CW'(FIFO_DEPTH));
            coef_q     <= coef_d;
            k_q        <= k_d;
            pcnt_q     <= pcnt_d;
            tmr_q      <= tmr_d;
            seen_q     <= seen_d;
            pend_q     <= pend_d;
            mw_q       <= modwait;
            sample_q   <= sample_d;
            fc_q       <= fc_d;
            dr_q       <= dr_d;
            lc_q       <= lc_d;
            cb_q       <= cb_d;
            err_q      <= err_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign fifo_count      = count_q;
    assign sample_data     = sample_q;
    assign data_ready      = dr_q;
    assign fir_coefficient = fc_q;
    assign load_coeff      = lc_q;
    assign coeff_busy      = cb_q;
    assign timeout_err     = err_q;

endmodule

// File: tb/tb_fir_input_sequencer.sv
`timescale 1ns/1ps
// Testbench for fir_input_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the sequencer.
module tb_fir_input_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int NC    = 4;
    localparam int LCP   = 2;
    localparam int STO   = 25;
    localparam int CTO   = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [NC*DW-1:0] coeff_set;
    logic             coeff_start;
    logic             modwait;
    logic [DW-1:0]    sample_data;
    logic             data_ready;
    logic [DW-1:0]    fir_coefficient;
    logic             load_coeff;
    logic             coeff_busy;
    logic [3:0]       fifo_count;
    logic             timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    fir_input_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .coeff_set       (coeff_set),
        .coeff_start     (coeff_start),
        .modwait         (modwait),
        .sample_data     (sample_data),
        .data_ready      (data_ready),
        .fir_coefficient (fir_coefficient),
        .load_coeff      (load_coeff),
        .coeff_busy      (coeff_busy),
        .fifo_count      (fifo_count),
        .timeout_err     (timeout_err)
    );

    // Filter stand-in: answers a request with modwait after fm_delay cycles,
    // held for fm_hold cycles; silent while fm_en is low.
    bit fm_en    = 1'b0;
    int fm_delay = 0;
    int fm_hold  = 3;

    initial begin
        modwait = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (fm_en && !reset && (data_ready || load_coeff)) begin
                for (int i = 0; i < fm_delay; i++) begin
                    @(posedge clk);
                    #1;
                end
                modwait = 1'b1;
                for (int i = 0; i < fm_hold; i++) begin
                    @(posedge clk);
                    #1;
                end
                modwait = 1'b0;
            end
        end
    end

    // Reference model: activity kind 0 none, 1 sample, 2 coefficients.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_coef [NC];
    int            m_kind, m_age, m_pulse, m_k;
    bit            m_gap, m_acked, m_seen, m_pend, m_mw;
    bit            m_started = 1'b0;
    logic [DW-1:0] m_sd, m_fc;
    bit            m_dr, m_lc, m_cb, m_err;

    function automatic void m_load();
        m_fc    = m_coef[m_k];
        m_lc    = 1'b1;
        m_pulse = LCP;
        m_age   = 0;
        m_seen  = 1'b0;
    endfunction

    function automatic void m_end(bit tmo);
        if (tmo) m_err = 1'b1;
        m_dr   = 1'b0;
        m_lc   = 1'b0;
        m_cb   = 1'b0;
        m_kind = 0;
        m_gap  = 1'b1;
    endfunction

    function automatic void m_step();
        bit rise, fall, room;
        if (reset) begin
            m_q.delete();
            m_kind = 0; m_gap = 1'b0; m_pend = 1'b0; m_mw = 1'b0;
            m_sd = '0; m_fc = '0;
            m_dr = 1'b0; m_lc = 1'b0; m_cb = 1'b0; m_err = 1'b0;
            m_started = 1'b1;
            return;
        end
        rise = modwait && !m_mw;
        fall = !modwait && m_mw;
        room = m_q.size() < DEPTH;
        if (m_kind == 0 && !m_gap) begin
            if (coeff_start || m_pend) begin
                for (int i = 0; i < NC; i++) m_coef[i] = coeff_set[i*DW +: DW];
                m_pend = 1'b0;
                m_kind = 2;
                m_k    = 0;
                m_cb   = 1'b1;
                m_load();
            end else if (m_q.size() > 0) begin
                m_sd    = m_q.pop_front();
                m_dr    = 1'b1;
                m_kind  = 1;
                m_age   = 0;
                m_acked = 1'b0;
            end
        end else begin
            if (coeff_start) m_pend = 1'b1;
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_kind == 1) begin
                m_age++;
                if (!m_acked) begin
                    if (m_age == STO) m_end(1'b1);
                    else if (rise) begin
                        m_acked = 1'b1;
                        m_dr    = 1'b0;
                    end
                end else begin
                    if (fall) m_end(1'b0);
                    else if (m_age == STO) m_end(1'b1);
                end
            end else begin
                m_age++;
                if (m_pulse > 0) begin
                    if (m_age == CTO) m_end(1'b1);
                    else begin
                        m_seen = m_seen || rise;
                        m_pulse--;
                        if (m_pulse == 0) m_lc = 1'b0;
                    end
                end else if (fall && m_seen) begin
                    m_k++;
                    if (m_k == NC) m_end(1'b0);
                    else m_load();
                end else if (m_age == CTO) begin
                    m_end(1'b1);
                end else begin
                    m_seen = m_seen || rise;
                end
            end
        end
        if (in_valid && room) m_q.push_back(in_data);
        m_mw = modwait;
    endfunction

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // Per-cycle compare plus transfer monitor.
    logic [DW-1:0] del[$];
    int            del_cyc[$];
    logic [DW-1:0] cq[$];
    int            lc_len[$];
    int            dr_len[$];
    int            cb_fall_cyc = -1;
    bit            p_dr = 0, p_lc = 0, p_cb = 0;
    int            dr_run = 0, lc_run = 0;

    initial forever begin
        @(negedge clk);
        if (m_started) begin
            cyc++;
            vectors++;
            if (data_ready !== m_dr || sample_data !== m_sd ||
                load_coeff !== m_lc || fir_coefficient !== m_fc ||
                coeff_busy !== m_cb || timeout_err !== m_err ||
                fifo_count !== 4'(m_q.size()) ||
                in_ready !== (m_q.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL cycle %0d: dut dr=%b sd=%h lc=%b fc=%h cb=%b to=%b cnt=%0d rdy=%b ; model dr=%b sd=%h lc=%b fc=%h cb=%b to=%b cnt=%0d rdy=%b",
                         cyc, data_ready, sample_data, load_coeff,
                         fir_coefficient, coeff_busy, timeout_err,
                         fifo_count, in_ready, m_dr, m_sd, m_lc, m_fc,
                         m_cb, m_err, m_q.size(), m_q.size() < DEPTH);
            end
            if (data_ready && !p_dr) begin
                del.push_back(sample_data);
                del_cyc.push_back(cyc);
            end
            if (load_coeff && !p_lc) cq.push_back(fir_coefficient);
            if (data_ready) dr_run++;
            else if (p_dr) begin
                dr_len.push_back(dr_run);
                dr_run = 0;
            end
            if (load_coeff) lc_run++;
            else if (p_lc) begin
                lc_len.push_back(lc_run);
                lc_run = 0;
            end
            if (!coeff_busy && p_cb) cb_fall_cyc = cyc;
            p_dr = data_ready;
            p_lc = load_coeff;
            p_cb = coeff_busy;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int v);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(v);
        for (int i = 0; i < 60 && !done; i++) begin
            acc = in_ready;
            tick();
            done = acc;
        end
        in_valid = 1'b0;
        chk("push_accepted", int'(done), 1);
    endtask

    logic [DW-1:0] exp_c [NC];

    initial begin
        exp_c       = '{16'h4000, 16'h8000, 16'h8000, 16'h4000};
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        coeff_start = 1'b0;
        coeff_set   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_data_ready", int'(data_ready), 0);
        chk("rst_load_coeff", int'(load_coeff), 0);
        chk("rst_coeff_busy", int'(coeff_busy), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_sample", int'(sample_data), 0);
        chk("rst_coef", int'(fir_coefficient), 0);
        reset = 1'b0;

        // Coefficient load
        fm_en = 1'b1; fm_delay = 0; fm_hold = 3;
        coeff_set = {16'h4000, 16'h8000, 16'h8000, 16'h4000};
        cq.delete(); lc_len.delete();
        coeff_start = 1'b1;
        tick();
        coeff_start = 1'b0;
        for (int i = 0; i < 200 && coeff_busy; i++) tick();
        chk("coef_busy_done", int'(coeff_busy), 0);
        chk("coef_pulses", cq.size(), NC);
        for (int k = 0; k < NC && k < cq.size(); k++) begin
            chk($sformatf("coef_val%0d", k), int'(cq[k]), int'(exp_c[k]));
            chk($sformatf("coef_len%0d", k), lc_len[k], LCP);
        end
        chk("coef_timeout", int'(timeout_err), 0);

        // FIFO fill with stalled filter, then drain in order
        fm_en = 1'b0;
        repeat (3) tick();
        del.delete();
        for (int v = 100; v <= 108; v++) push_one(v);
        chk("fill_count", int'(fifo_count), 8);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_head_out", int'(sample_data), 100);
        fm_en = 1'b1;
        for (int i = 0; i < 400 && (del.size() < 9 || data_ready); i++) tick();
        repeat (6) tick();
        chk("drain_n", del.size(), 9);
        for (int k = 0; k < 9 && k < del.size(); k++)
            chk($sformatf("drain_val%0d", k), int'(del[k]), 100 + k);
        chk("drain_timeout", int'(timeout_err), 0);

        // Sample timeout
        fm_en = 1'b0;
        del.delete(); dr_len.delete();
        push_one(200);
        push_one(201);
        for (int i = 0; i < 100 && dr_len.size() == 0; i++) tick();
        fm_en = 1'b1;
        chk("tmo_seen", dr_len.size(), 1);
        if (dr_len.size() > 0) chk("tmo_len", dr_len[0], STO);
        chk("tmo_err", int'(timeout_err), 1);
        for (int i = 0; i < 100 && (del.size() < 2 || data_ready); i++) tick();
        repeat (6) tick();
        chk("tmo_next_n", del.size(), 2);
        if (del.size() > 1) chk("tmo_next_val", int'(del[1]), 201);
        chk("tmo_sticky", int'(timeout_err), 1);

        // coeff_start during S_WAIT
        repeat (4) tick();
        del.delete(); del_cyc.delete(); cq.delete();
        cb_fall_cyc = -1;
        push_one(300);
        for (int i = 0; i < 50 && !data_ready; i++) tick();
        for (int i = 0; i < 50 && data_ready; i++) tick();
        coeff_start = 1'b1;
        tick();
        coeff_start = 1'b0;
        push_one(301);
        push_one(302);
        for (int i = 0; i < 400 && (del.size() < 3 || data_ready); i++) tick();
        repeat (6) tick();
        chk("mix_n", del.size(), 3);
        for (int k = 0; k < 3 && k < del.size(); k++)
            chk($sformatf("mix_val%0d", k), int'(del[k]), 300 + k);
        chk("mix_coef_n", cq.size(), NC);
        if (del_cyc.size() > 1)
            chk("mix_order", int'(cb_fall_cyc > 0 && del_cyc[1] > cb_fall_cyc), 1);

        // Reset in S_REQ with samples queued
        repeat (4) tick();
        fm_en = 1'b0;
        for (int v = 400; v <= 403; v++) push_one(v);
        chk("pre_rst_count", int'(fifo_count), 3);
        chk("pre_rst_dr", int'(data_ready), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_dr", int'(data_ready), 0);
        chk("mid_rst_count", int'(fifo_count), 0);
        chk("mid_rst_err", int'(timeout_err), 0);
        del.delete();
        fm_en = 1'b1;
        repeat (40) tick();
        chk("no_stale", del.size(), 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_data     = DW'($urandom);
            coeff_start = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) coeff_set = {$urandom, $urandom};
            if (fm_en && $urandom_range(0, 149) == 0) fm_en = 1'b0;
            else if (!fm_en && $urandom_range(0, 29) == 0) fm_en = 1'b1;
            fm_delay = $urandom_range(0, 3);
            fm_hold  = $urandom_range(1, 4);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid    = 1'b0;
        coeff_start = 1'b0;
        reset       = 1'b0;
        fm_en       = 1'b1;
        repeat (60) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
